func_sequencer: RTL

- Sits directly upstream of the cube-plus-sqrt function unit (a^3 + sqrt(b)).
- Buffers operand pairs in a small FIFO and issues them to the unit one at a time using its start/busy handshake.
- Captures each 16-bit result and presents it on a valid/ready output port.
- Adds a watchdog and a completed-operation counter for board-level debug.

---
 rtl/func_sequencer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/func_sequencer.sv
// Issue sequencer for the a^3 + sqrt(b) function unit: operand FIFO, start/busy
// handshake, registered valid/ready result port, watchdog and completion counter.
module func_sequencer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic        full_o,
  output logic        empty_o,
  output logic        fu_start_o,
  output logic [7:0]  fu_a_o,
  output logic [7:0]  fu_b_o,
  input  logic [1:0]  fu_busy_i,
  input  logic [15:0] fu_y_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [15:0] res_o,
  output logic        err_o,
  output logic [7:0]  done_cnt_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);
  localparam logic [AW-1:0] ONE_PTR  = AW'(1);
  localparam logic [7:0]    WD_LIMIT = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  // Operand storage: each entry is {a, b}
  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q;
  logic          push_ok, pop;
  logic [15:0]   head;

  state_t        state_q, state_d;
  logic          start_q, start_d;
  logic [7:0]    fu_a_q, fu_a_d;
  logic [7:0]    fu_b_q, fu_b_d;
  logic [7:0]    wd_q, wd_d;
  logic [7:0]    wd_inc;
  logic          wd_expired;
  logic [15:0]   res_q, res_d;
  logic          res_valid_q, res_valid_d;
  logic [7:0]    done_q, done_d;
  logic          err_q, err_d;

  // A full FIFO drops the push even when the same edge pops an entry
  assign push_ok = push_i && !full_q;
  assign pop     = (state_q == S_IDLE) && !empty_q && !res_valid_q;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + ONE_CNT;
    end else if (!push_ok && pop) begin
      count_d = count_q - ONE_CNT;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= {a_i, b_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + ONE_PTR;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + ONE_PTR;
      end
      count_q <= count_d;
      full_q  <= (count_d == FULL_CNT);
      empty_q <= (count_d == '0);
    end
  end

  assign wd_inc     = wd_q + 8'd1;
  assign wd_expired = (wd_inc == WD_LIMIT);

  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    fu_a_d      = fu_a_q;
    fu_b_d      = fu_b_q;
    wd_d        = wd_q;
    res_d       = res_q;
    res_valid_d = res_valid_q;
    done_d      = done_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          fu_a_d  = head[15:8];
          fu_b_d  = head[7:0];
          start_d = 1'b1;
          wd_d    = 8'd0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (fu_busy_i != 2'd0) begin
          start_d = 1'b0;
          wd_d    = 8'd0;
          state_d = S_WAIT;
        end else if (wd_expired) begin
          err_d   = 1'b1;
          start_d = 1'b0;
          wd_d    = 8'd0;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_inc;
        end
      end
      S_WAIT: begin
        if (fu_busy_i == 2'd0) begin
          res_d       = fu_y_i;
          res_valid_d = 1'b1;
          done_d      = done_q + 8'd1;
          state_d     = S_HOLD;
        end else if (wd_expired) begin
          // Abandon the operation: no result, counter untouched, move on
          err_d   = 1'b1;
          start_d = 1'b0;
          wd_d    = 8'd0;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_inc;
        end
      end
      S_HOLD: begin
        if (res_ready_i) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      fu_a_q      <= 8'd0;
      fu_b_q      <= 8'd0;
      wd_q        <= 8'd0;
      res_q       <= 16'd0;
      res_valid_q <= 1'b0;
      done_q      <= 8'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      fu_a_q      <= fu_a_d;
      fu_b_q      <= fu_b_d;
      wd_q        <= wd_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign full_o      = full_q;
  assign empty_o     = empty_q;
  assign fu_start_o  = start_q;
  assign fu_a_o      = fu_a_q;
  assign fu_b_o      = fu_b_q;
  assign res_valid_o = res_valid_q;
  assign res_o       = res_q;
  assign err_o       = err_q;
  assign done_cnt_o  = done_q;

endmodule
